// File: rtl/f1_pkg.sv
// f1_pkg: shared state encoding and constants for the F1 start-light sequencer.
package f1_pkg;
  typedef enum logic [1:0] {IDLE, LIGHTS, HOLD, TIMING} f1_state_t;
  localparam int F1_N_LIGHTS = 8;
  localparam int F1_RT_W = 16;
  localparam logic [6:0] F1_DELAY_MASK = 7'h7F;
endpackage

// File: rtl/f1_light_seq_tick_gen.sv
// tick_gen: one-cycle tick every TICK_CYCLES clocks, held at phase zero while clr is high.
module tick_gen #(
  parameter int TICK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == CW'(TICK_CYCLES - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/f1_light_seq.sv
// f1_light_seq: F1 start-light sequencer with random hold and reaction timer.
// Define F1_JUMP_START_EN to abort the start and flag a false start on early react.
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int TICK_CYCLES = 1000,
  parameter int N_LIGHTS = F1_N_LIGHTS,
  parameter int RT_W = F1_RT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                react,
  input  logic [7:0]          lfsr_data,
  output logic                lfsr_en,
  output logic [N_LIGHTS-1:0] lights,
  output logic                busy,
  output logic [RT_W-1:0]     reaction_time,
  output logic                reaction_valid,
  output logic                jump_start
);
`ifdef F1_JUMP_START_EN
  localparam bit JS_EN = 1'b1;
`else
  localparam bit JS_EN = 1'b0;
`endif
  f1_state_t state_q, state_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic [7:0] hold_q, hold_d;
  logic [RT_W-1:0] rt_q, rt_d, rtime_q, rtime_d;
  logic valid_q, valid_d, js_q, js_d, tick, early;
  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state_q == IDLE),
    .tick(tick)
  );
  assign early = JS_EN && react && (state_q == LIGHTS || state_q == HOLD);
  always_comb begin
    state_d = state_q;
    lights_d = lights_q;
    hold_d = hold_q;
    rt_d = rt_q;
    rtime_d = rtime_q;
    valid_d = 1'b0;
    js_d = js_q;
    if (early) begin
      state_d = IDLE;
      lights_d = '0;
      js_d = 1'b1;
      rtime_d = '0;
      valid_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (trigger) begin
          state_d = LIGHTS;
          lights_d = '0;
          js_d = 1'b0;
        end
        LIGHTS: if (tick) begin
          lights_d = {lights_q[N_LIGHTS-2:0], 1'b1};
          if (&lights_q[N_LIGHTS-2:0]) begin
            state_d = HOLD;
            hold_d = (lfsr_data & {1'b0, F1_DELAY_MASK}) + 8'd1;
          end
        end
        HOLD: if (tick) begin
          if (hold_q == 8'd1) begin
            state_d = TIMING;
            lights_d = '0;
            rt_d = '0;
          end else hold_d = hold_q - 8'd1;
        end
        TIMING: if (react) begin
          state_d = IDLE;
          rtime_d = rt_q;
          valid_d = 1'b1;
        end else if (tick && rt_q != '1) rt_d = rt_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      lights_q <= '0;
      hold_q <= '0;
      rt_q <= '0;
      rtime_q <= '0;
      valid_q <= 1'b0;
      js_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lights_q <= lights_d;
      hold_q <= hold_d;
      rt_q <= rt_d;
      rtime_q <= rtime_d;
      valid_q <= valid_d;
      js_q <= js_d;
    end
  assign lfsr_en = state_q == IDLE || state_q == LIGHTS;
  assign busy = state_q != IDLE;
  assign lights = lights_q;
  assign reaction_time = rtime_q;
  assign reaction_valid = valid_q;
  assign jump_start = JS_EN && js_q;
endmodule

// File: tb/tb_f1_light_seq.sv
// tb_f1_light_seq: directed and randomized checks of the light sequencer against a timing model.
module tb_f1_light_seq;
  localparam int T = 4;
  localparam int NL = 8;
  logic clk = 1'b0, rst = 1'b0, trigger = 1'b0, react = 1'b0;
  logic [7:0] lfsr_data = 8'h00;
  logic lfsr_en, busy, reaction_valid, jump_start;
  logic [7:0] lights;
  logic [15:0] reaction_time;
  logic s_lfsr_en, s_busy, s_valid, s_js;
  logic [7:0] s_lights;
  logic [3:0] s_rtime;
  int checks = 0, errors = 0, last_rt = 0;
  always #5 clk = ~clk;
  f1_light_seq #(.TICK_CYCLES(T)) u_dut (
    .clk(clk), .rst(rst), .trigger(trigger), .react(react), .lfsr_data(lfsr_data),
    .lfsr_en(lfsr_en), .lights(lights), .busy(busy), .reaction_time(reaction_time),
    .reaction_valid(reaction_valid), .jump_start(jump_start)
  );
  f1_light_seq #(.TICK_CYCLES(T), .RT_W(4)) u_sat (
    .clk(clk), .rst(rst), .trigger(trigger), .react(react), .lfsr_data(lfsr_data),
    .lfsr_en(s_lfsr_en), .lights(s_lights), .busy(s_busy), .reaction_time(s_rtime),
    .reaction_valid(s_valid), .jump_start(s_js)
  );
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One full start: trigger, ramp, hold, then press react on the m-th edge into TIMING.
  task automatic run_seq(input logic [7:0] d, input int m, input bit noise);
    int hold_c, exp_l, rt;
    lfsr_data = d;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("trig_busy", 32'(busy), 1);
    chk("trig_lights", 32'(lights), 0);
    hold_c = (int'(d % 128) + 1) * T;
    for (int c = 1; c <= NL * T + hold_c; c++) begin
      trigger = noise && c == 5;
`ifndef F1_JUMP_START_EN
      react = noise && c == NL * T + 1;
`endif
      step();
      exp_l = c < NL * T + hold_c ? (1 << (c / T > NL ? NL : c / T)) - 1 : 0;
      chk("ramp_lights", 32'(lights), 32'(exp_l));
      chk("ramp_lfsr_en", 32'(lfsr_en), c < NL * T ? 1 : 0);
      chk("ramp_busy", 32'(busy), 1);
    end
    trigger = 1'b0;
    react = 1'b0;
    if (m > 1) step(m - 1);
    chk("timing_valid_lo", 32'(reaction_valid), 0);
    chk("timing_busy", 32'(busy), 1);
    react = 1'b1;
    step();
    rt = (m - 1) / T;
    chk("react_valid", 32'(reaction_valid), 1);
    chk("react_time", 32'(reaction_time), 32'(rt));
    chk("react_busy", 32'(busy), 0);
    chk("sat_time", 32'(s_rtime), 32'(rt > 15 ? 15 : rt));
    last_rt = rt;
    step();
    react = 1'b0;
    chk("valid_pulse", 32'(reaction_valid), 0);
    chk("time_hold", 32'(reaction_time), 32'(rt));
    chk("idle_lfsr_en", 32'(lfsr_en), 1);
  endtask
  initial begin
    step(2);
    chk("rst_lights", 32'(lights), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_lfsr_en", 32'(lfsr_en), 1);
    chk("rst_valid", 32'(reaction_valid), 0);
    chk("rst_time", 32'(reaction_time), 0);
    chk("rst_js", 32'(jump_start), 0);
    rst = 1'b1;
    step(3);
    chk("idle_busy", 32'(busy), 0);
    run_seq(8'h05, 10 * T + 1, 1'b1);
    run_seq(8'h80, 13, 1'b0);
    run_seq(8'h3A, 100, 1'b0);
    lfsr_data = 8'h11;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step(3 * T);
    chk("js_pre_lights", 32'(lights), 32'h07);
    react = 1'b1;
    step();
    react = 1'b0;
`ifdef F1_JUMP_START_EN
    chk("js_lights", 32'(lights), 0);
    chk("js_flag", 32'(jump_start), 1);
    chk("js_time", 32'(reaction_time), 0);
    chk("js_valid", 32'(reaction_valid), 1);
    chk("js_busy", 32'(busy), 0);
    step();
    chk("js_valid_lo", 32'(reaction_valid), 0);
    chk("js_sticky", 32'(jump_start), 1);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("js_clear", 32'(jump_start), 0);
    chk("js_retrig_busy", 32'(busy), 1);
`else
    chk("js_lights", 32'(lights), 32'h07);
    chk("js_flag", 32'(jump_start), 0);
    chk("js_time", 32'(reaction_time), 32'(last_rt));
    chk("js_valid", 32'(reaction_valid), 0);
    chk("js_busy", 32'(busy), 1);
`endif
    #3 rst = 1'b0;
    #1;
    chk("arst_lights", 32'(lights), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_time", 32'(reaction_time), 0);
    #1 rst = 1'b1;
    step(2);
    lfsr_data = 8'h20;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step(NL * T + 5);
    chk("hold_pre_lights", 32'(lights), 32'hFF);
    chk("hold_pre_lfsr_en", 32'(lfsr_en), 0);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_lights", 32'(lights), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_lfsr_en", 32'(lfsr_en), 1);
    chk("mid_rst_valid", 32'(reaction_valid), 0);
    #1 rst = 1'b1;
    step(3);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_lights", 32'(lights), 0);
    for (int i = 0; i < 6; i++) begin
      step($urandom_range(0, 5));
      run_seq(8'($urandom), int'($urandom_range(1, 90)), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
